// File: rtl/tenbaset_tx_ctrl_if.sv
// tenbaset_tx_ctrl_if: frame request, serializer tap and FCS/control strobes between
// the 10BASE-T TX controller (slave) and the host/serializer side (master).
interface tenbaset_tx_ctrl_if #(
  parameter int LEN_W = 11
);
  logic             start;
  logic [LEN_W-1:0] pkt_len;
  logic             ShiftData;
  logic [3:0]       ShiftCount;
  logic             SendingPacket;
  logic             CRCflush;
  logic             CRC;
  logic             busy;
  logic             done;
  modport master (
    output start, pkt_len, ShiftData, ShiftCount,
    input  SendingPacket, CRCflush, CRC, busy, done
  );
  modport slave (
    input  start, pkt_len, ShiftData, ShiftCount,
    output SendingPacket, CRCflush, CRC, busy, done
  );
endinterface

// File: rtl/tenbaset_tx_ctrl.sv
// tenbaset_tx_ctrl: frame sequencer for the 10BASE-T serializer; computes the CRC-32 from the
// serial bit stream, switches the serializer to FCS mode and enforces the inter-frame gap.
module tenbaset_tx_ctrl #(
  parameter int LEN_W   = 11,
  parameter int IFG_CYC = 192
) (
  input logic               clk20,
  input logic               rst_n,
  tenbaset_tx_ctrl_if.slave bus
);
  localparam int CYC_W = LEN_W + 5;
  localparam int GAP_W = (IFG_CYC > 2) ? $clog2(IFG_CYC) : 1;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  logic [1:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic [31:0]      crc_q, crc_d;
  logic             sp_q, sp_d, flush_q, flush_d, busy_q, busy_d, done_q, done_d;
  logic             armed_q;
  logic             accept, last, gap_end, feed, pad;
  logic [CYC_W-1:0] flush_cyc, last_cyc;
  assign flush_cyc = CYC_W'({len_q, 4'd0});
  assign last_cyc  = flush_cyc + CYC_W'(64);
  // armed_q blocks a start that coincides with reset release
  assign accept  = (state_q == IDLE) && armed_q && bus.start && (bus.pkt_len >= LEN_W'(9));
  assign last    = (state_q == SEND) && (cyc_q == last_cyc);
  assign gap_end = (state_q == GAP) && (gap_q == GAP_W'(IFG_CYC - 1));
  // data bits enter the CRC from byte 8 on (cyc >= 129), one update per bit on the odd phase
  assign feed = (state_q == SEND) && bus.ShiftCount[0] && !flush_q && (cyc_q > CYC_W'(128));
  assign pad  = (state_q == SEND) && bus.ShiftCount[0] && flush_q;
  always_comb begin
    state_d = accept ? SEND : last ? GAP : gap_end ? IDLE : state_q;
    len_d   = accept ? bus.pkt_len : len_q;
    cyc_d   = accept ? '0 : (state_q == SEND) ? cyc_q + CYC_W'(1) : cyc_q;
    gap_d   = (state_q == GAP) ? gap_q + GAP_W'(1) : '0;
    crc_d   = accept ? 32'hFFFF_FFFF :
              feed   ? ({crc_q[30:0], 1'b0} ^ ((bus.ShiftData ^ crc_q[31]) ? POLY : 32'd0)) :
              pad    ? {crc_q[30:0], 1'b1} : crc_q;
    sp_d    = (state_d == SEND);
    flush_d = (state_q == SEND) && !last && (flush_q || (cyc_q == flush_cyc));
    busy_d  = (state_d != IDLE);
    done_d  = last;
  end
  always_ff @(posedge clk20 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q   <= '0;
      cyc_q   <= '0;
      gap_q   <= '0;
      crc_q   <= 32'hFFFF_FFFF;
      sp_q    <= 1'b0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cyc_q   <= cyc_d;
      gap_q   <= gap_d;
      crc_q   <= crc_d;
      sp_q    <= sp_d;
      flush_q <= flush_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      armed_q <= 1'b1;
    end
  end
  assign bus.SendingPacket = sp_q;
  assign bus.CRCflush      = flush_q;
  assign bus.CRC           = ~crc_q[31];
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;
endmodule

// File: tb/tb_tenbaset_tx_ctrl.sv
// tb_tenbaset_tx_ctrl: drives a serializer model from a byte RAM and checks frame timing and
// the serial FCS against a byte-wise reflected CRC-32 software model.
module tb_tenbaset_tx_ctrl;
  localparam int LEN_W = 11;
  localparam int IFG   = 192;
  logic clk20 = 1'b0;
  logic rst_n = 1'b1;
  tenbaset_tx_ctrl_if #(.LEN_W(LEN_W)) bus ();
  tenbaset_tx_ctrl #(.LEN_W(LEN_W), .IFG_CYC(IFG)) dut (.clk20(clk20), .rst_n(rst_n), .bus(bus));
  always #25 clk20 = ~clk20;
  logic [7:0]  mem [0:2047];
  int          checks = 0;
  int          errors = 0;
  int          c = 0;
  logic        prev_sp = 1'b0;
  int          lat, sp_n, fl_n, fl_bad, dn, gap;
  logic [31:0] fcs;

  function automatic logic [31:0] ref_fcs(input int len);
    logic [31:0] r = 32'hFFFF_FFFF;
    for (int i = 8; i < len; i++) begin
      r = r ^ {24'd0, mem[i]};
      for (int j = 0; j < 8; j++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return ~r;
  endfunction

  task automatic step();
    @(negedge clk20);
    if (bus.SendingPacket) c = prev_sp ? c + 1 : 0;
    prev_sp = bus.SendingPacket;
    if (bus.SendingPacket && c > 0) begin
      bus.ShiftCount = 4'((c - 1) % 16);
      bus.ShiftData  = ((c - 1) / 16 < 2048) ? mem[(c - 1) / 16][((c - 1) % 16) / 2] : 1'b0;
    end else begin
      bus.ShiftCount = 4'd15;
      bus.ShiftData  = 1'b0;
    end
  endtask

  task automatic load_preamble();
    for (int i = 0; i < 7; i++) mem[i] = 8'h55;
    mem[7] = 8'hD5;
  endtask

  task automatic load_known();
    load_preamble();
    for (int i = 0; i < 9; i++) mem[8 + i] = 8'h31 + 8'(i);
  endtask

  task automatic load_random(input int len);
    load_preamble();
    for (int i = 8; i < len; i++) mem[i] = 8'($urandom);
  endtask

  task automatic run_frame(input int len, input bit hold);
    int k = 0;
    bus.pkt_len = LEN_W'(len);
    bus.start   = 1'b1;
    lat = 0;
    step();
    while (!bus.SendingPacket && lat < 8) begin lat++; step(); end
    if (!hold) bus.start = 1'b0;
    sp_n = 0; fl_n = 0; fl_bad = 0; dn = 0; fcs = '0;
    while (bus.SendingPacket && sp_n < 40000) begin
      sp_n++;
      if (bus.CRCflush) fl_n++;
      if (bus.CRCflush !== (c >= 16 * len + 1)) fl_bad++;
      if (bus.done) dn++;
      if (bus.CRCflush && ((c - 1) % 2 == 0) && k < 32) begin fcs[k] = bus.CRC; k++; end
      step();
    end
    gap = 0;
    while (bus.busy && gap < 1000) begin
      if (bus.done) dn++;
      gap++;
      step();
    end
  endtask

  task automatic check_frame(input string name, input int len);
    checks++; if (lat !== 0) begin errors++; $display("FAIL %s_latency: got %0d expected 0", name, lat); end
    checks++; if (sp_n !== 16 * (len + 4) + 1) begin errors++; $display("FAIL %s_send_len: got %0d expected %0d", name, sp_n, 16 * (len + 4) + 1); end
    checks++; if (fl_n !== 64 || fl_bad !== 0) begin errors++; $display("FAIL %s_flush: got %0d cycles %0d misplaced expected 64/0", name, fl_n, fl_bad); end
    checks++; if (fcs !== ref_fcs(len)) begin errors++; $display("FAIL %s_fcs: got %08h expected %08h", name, fcs, ref_fcs(len)); end
    checks++; if (dn !== 1) begin errors++; $display("FAIL %s_done: got %0d pulses expected 1", name, dn); end
    checks++; if (gap !== IFG) begin errors++; $display("FAIL %s_gap: got %0d expected %0d", name, gap, IFG); end
  endtask

  task automatic test_reset();
    #5 rst_n = 1'b0;
    repeat (4) step();
    checks++;
    if ({bus.SendingPacket, bus.CRCflush, bus.busy, bus.done, bus.CRC} !== 5'd0) begin
      errors++; $display("FAIL reset_outputs: got %05b expected 00000", {bus.SendingPacket, bus.CRCflush, bus.busy, bus.done, bus.CRC});
    end
    load_known();
    bus.pkt_len = LEN_W'(17);
    bus.start   = 1'b1;
    rst_n       = 1'b1;
    step();
    bus.start = 1'b0;
    step(); step();
    checks++;
    if ({bus.SendingPacket, bus.busy} !== 2'b00) begin
      errors++; $display("FAIL reset_release_start: got %02b expected 00", {bus.SendingPacket, bus.busy});
    end
  endtask

  task automatic test_known_fcs();
    load_known();
    run_frame(17, 1'b0);
    checks++; if (fcs !== 32'hCBF43926) begin errors++; $display("FAIL known_fcs_const: got %08h expected cbf43926", fcs); end
    check_frame("known", 17);
  endtask

  task automatic test_short();
    int hits = 0;
    bus.pkt_len = LEN_W'(8);
    bus.start   = 1'b1;
    repeat (20) begin step(); if (bus.SendingPacket || bus.busy) hits++; end
    bus.start = 1'b0;
    step();
    checks++; if (hits !== 0) begin errors++; $display("FAIL short_len: got %0d active cycles expected 0", hits); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int len = $urandom_range(9, 80);
      load_random(len);
      repeat ($urandom_range(0, 5)) step();
      run_frame(len, 1'b0);
      check_frame("random", len);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 3; f++) begin
      int len = $urandom_range(9, 40);
      load_random(len);
      run_frame(len, 1'b1);
      check_frame("b2b", len);
    end
    bus.start = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_frame();
    int guard = 0;
    load_known();
    bus.pkt_len = LEN_W'(17);
    bus.start   = 1'b1;
    step();
    bus.start = 1'b0;
    while (c < 100 && guard < 200) begin guard++; step(); end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.SendingPacket, bus.CRCflush, bus.busy, bus.done} !== 4'd0) begin
      errors++; $display("FAIL reset_mid_async: got %04b expected 0000", {bus.SendingPacket, bus.CRCflush, bus.busy, bus.done});
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (2) step();
    checks++;
    if ({bus.SendingPacket, bus.done} !== 2'b00) begin
      errors++; $display("FAIL reset_mid_abort: got %02b expected 00", {bus.SendingPacket, bus.done});
    end
    run_frame(17, 1'b0);
    checks++; if (fcs !== 32'hCBF43926) begin errors++; $display("FAIL reset_mid_fcs: got %08h expected cbf43926", fcs); end
    check_frame("after_reset", 17);
  endtask

  task automatic test_max_len();
    load_random(2047);
    run_frame(2047, 1'b0);
    check_frame("max_len", 2047);
  endtask

  initial begin
    bus.start      = 1'b0;
    bus.pkt_len    = '0;
    bus.ShiftCount = 4'd15;
    bus.ShiftData  = 1'b0;
    test_reset();
    test_known_fcs();
    test_short();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    test_max_len();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/tenbaset_tx_ctrl.md
# tenbaset_tx_ctrl

Frame sequencer and FCS generator sitting directly upstream of the 10BASE-T transmit serializer. On a start request it drives `SendingPacket` for exactly the frame duration, watches the serializer's bit stream to compute the Ethernet CRC-32, then switches the serializer to CRC mode (`CRCflush`/`CRC`) for the 4 FCS bytes. After each frame it enforces the inter-frame gap. The frame bytes themselves (preamble, SFD, header, payload) come from packet RAM read by the serializer.

## Interface
- `LEN_W`, 11: width of `pkt_len`; matches the serializer's RAM address width.
- `IFG_CYC`, 192: inter-frame gap in clk20 cycles (96 bit times at 2 cycles/bit).

- `clk20`  in  1  20 MHz clock, the only clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to send the frame currently in RAM.
- `pkt_len`  in  LEN_W  RAM frame length in bytes, including 8 preamble/SFD bytes, excluding FCS; sampled on accepted `start`.
- `ShiftData`  in  1  serializer shift-register bit 0 (current data bit).
- `ShiftCount`  in  4  serializer phase counter (15 while idle).
- `SendingPacket`  out  1  frame-active strobe to the serializer.
- `CRCflush`  out  1  high while the FCS bytes are transmitted.
- `CRC`  out  1  serial FCS bit, valid while `CRCflush` is high.
- `busy`  out  1  high in SEND or GAP.
- `done`  out  1  one-cycle pulse on the SEND→GAP transition.

## Operation
- FSM states: IDLE, SEND, GAP.
- IDLE: `start`=1 and `pkt_len`≥9 → latch `len`, preset `crc`=32'hFFFFFFFF, clear cycle counter `cyc`, go SEND. `start` with `pkt_len`<9 is ignored.
- SEND: `SendingPacket`=1. `cyc` increments every cycle. Frame bytes N = len+4. Total SEND duration is exactly 16·N+1 cycles: the first cycle is the serializer load cycle (ShiftCount=15), followed by 16 cycles per byte. On the last SEND cycle, go GAP and pulse `done`.
- Byte index b = (cyc−1)>>4, for cyc≥1. Bit k of byte b is presented on ShiftCount 2k and 2k+1.
- CRC update: on each SEND cycle with ShiftCount[0]=1, 8≤b<len, and `CRCflush`=0:
  - fb = ShiftData ^ crc[31]
  - crc ← {crc[30:0],1'b0} ^ (fb ? 32'h04C11DB7 : 0)
  - Preamble/SFD bytes (b<8) are not included in the CRC.
- `CRCflush` = 1 in SEND when b≥len, i.e. for the final 64 cycles.
- `CRC` = ~crc[31]. During flush, on each cycle with ShiftCount[0]=1: crc ← {crc[30:0],1'b1}.
- GAP: `SendingPacket`=0; count `IFG_CYC` cycles, then go IDLE. `start` is ignored in SEND and GAP; there is no queueing.
- Width rules: `cyc` is LEN_W+5 bits, so 16·(2^LEN_W+4)+1 never overflows. All comparisons are unsigned.

## Timing
- Reset values: all outputs 0, state IDLE, `crc`=all ones, counters 0. Asserting `rst_n` mid-frame drops `SendingPacket`/`CRCflush` immediately (async) and aborts the frame; no `done` is issued.
- All outputs are registered except `CRC`, which is combinational from `crc[31]`.
- `SendingPacket` rises in the cycle after the accepted `start` (1-cycle latency).
- `CRCflush` rises in the same cycle as byte index len becomes active, at ShiftCount=0 of the first FCS byte. It falls together with `SendingPacket`.
- Start-to-start minimum spacing: 16·N+1+IFG_CYC+1 cycles.
- `start` coincident with reset release is ignored.
- `start` on the cycle GAP returns to IDLE is ignored; `start` on the following IDLE cycle is accepted.

## Test plan
- Known FCS: RAM = 55×7, D5, ASCII "123456789" (pkt_len=17), start → `SendingPacket` high 337 cycles; serial FCS bytes LSB-first equal 26 39 F4 CB (CRC-32 0xCBF43926).
- Flush window: same frame → `CRCflush` high exactly the last 64 SEND cycles; `done` pulses once; `busy` falls exactly 192 cycles after `SendingPacket` falls.
- Back-to-back: `start` asserted every cycle → frames separated by exactly 192 idle cycles plus 1 IDLE cycle; no overlap; no `done` without a frame.
- Short length: pkt_len=8 with start → no `SendingPacket`, `busy` stays 0.
- Reset mid-frame: assert `rst_n`=0 at cycle 100 of SEND → `SendingPacket`/`CRCflush`/`busy` 0 asynchronously. The next frame after release reproduces the 0xCBF43926 FCS.
- Max length: pkt_len=2047 → SEND lasts 16·2051+1 = 32817 cycles with no counter wrap; FCS matches the software model.
